udp_decoder: RTL and testbench
==============================

Name: udp_decoder

Overview:
Receive-side counterpart of the UDP transmit path. Accepts one UDP datagram as a stream of 32-bit words (header first, big-endian byte order, byte 0 in [31:24]). Strips and latches the 8-byte header and forwards payload words with byte enables. Verifies the one's-complement checksum over pseudo-header, header and payload, then reports completion status to the IP receive layer.

Parameters:
MAX_LEN, 16'd65535, largest accepted UDP length field in bytes; a larger value flags err.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  pulse in IDLE begins a datagram; ignored in other states
src_ip  in  32  IPv4 source address for the pseudo-header; stable from start to fin
dest_ip  in  32  IPv4 destination address for the pseudo-header; stable from start to fin
data  in  32  input word
data_av  in  1  data holds a valid word this cycle; gaps allowed
src_port  out  16  latched header source port
dest_port  out  16  latched header destination port
len_out  out  16  payload length in bytes (UDP length - 8)
data_out  out  32  payload word, unused bytes forced to 0
byte_en  out  4  valid payload bytes of data_out; bit 3 = [31:24]
wr_en  out  1  data_out/byte_en valid this cycle
last  out  1  with wr_en: final payload word
fin  out  1  held high from end of datagram until next start
chksum_ok  out  1  valid while fin; 1 = checksum passed or not present
err  out  1  valid while fin; length error

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs and internal accumulators = 0.
- States: IDLE -> HDR_1 on start. HDR_1 -> HDR_2 on data_av. HDR_2 -> DATA on data_av if 8 < length <= MAX_LEN; -> CHECK if length == 8; -> FIN with err=1 if length < 8 or length > MAX_LEN. DATA -> CHECK when last payload word accepted. CHECK -> FIN unconditionally after 1 cycle. FIN -> HDR_1 on start (fin, chksum_ok, err cleared same edge); otherwise stays in FIN.
- HDR_1 word: {src_port, dest_port}, latched on accept. HDR_2 word: {length, rx_checksum}; len_out <= length - 8 registered on accept.
- Payload words = ceil(len_out/4). Internal bytes_left counter loaded with len_out, decremented by 4 (saturating at 0) per accepted word.
- Payload latency: data_out/wr_en registered 1 cycle after data_av. wr_en is a 1-cycle pulse per word; 0 in all non-DATA cycles. Final word: byte_en = 4'b1111, 4'b1110, 4'b1100 or 4'b1000 for len_out mod 4 = 0, 3, 2, 1; last=1. Masked bytes zeroed on data_out and in the checksum.
- data_av in IDLE, CHECK or FIN, or beyond the payload word count: ignored; no wr_en, no checksum effect.
- Checksum: a 32-bit end-around-carry accumulator sums every accepted header and masked payload word, including rx_checksum. CHECK adds the pseudo-header (src_ip, dest_ip, 16'h0011, length), folds to 16 bits with end-around carry, and compares to 16'hFFFF. chksum_ok = 1 if the fold equals 16'hFFFF or rx_checksum == 0.
- err=1 forces chksum_ok=0. No payload wr_en is issued for error datagrams.
- Reset asserted mid-datagram: immediate return to IDLE; no fin; partial payload already written is the consumer's responsibility.

Optional Feature:
UDP_DEC_PORT_FILTER_EN: adds input port listen_port (16). When defined, a dest_port mismatch on the HDR_1 accept sets an internal drop flag. The remaining words are consumed normally but wr_en is suppressed. At fin, err=1 and chksum_ok=0. When undefined, the port does not exist and all ports are accepted.

Test Plan:
- Basic: src_ip C0A80001, dest_ip C0A80002, words 12345678, 000C7838, DEADBEEF -> one wr_en with data_out DEADBEEF, byte_en 1111, last=1; src_port 1234, dest_port 5678, len_out 4; fin with chksum_ok=1, err=0.
- Bad checksum: same datagram with second word 000C7839 -> same payload output; fin with chksum_ok=0, err=0.
- No checksum: second word 000C0000 -> chksum_ok=1.
- Odd length: length 000D, payload AABBCCDD, EEFF0011 (idle data_av gaps between words) -> outputs AABBCCDD/1111, then EE000000/1000 with last=1; len_out 5; extra words after this are ignored.
- Length error: second word 00060000 -> no wr_en; fin with err=1, chksum_ok=0. Length 0008 -> no wr_en; fin with err=0.
- Reset mid-payload: drive reset=0 between payload words -> outputs 0 asynchronously; a following start plus the basic datagram decodes correctly.

Source files
------------

// File: rtl/udp_decoder.sv
// udp_decoder: strips the UDP header from a 32-bit word stream, forwards payload with byte enables, verifies checksum; optional listen-port filter via UDP_DEC_PORT_FILTER_EN
module udp_decoder #(
  parameter logic [15:0] MAX_LEN = 16'd65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_ip,
  input  logic [31:0] dest_ip,
  input  logic [31:0] data,
  input  logic        data_av,
`ifdef UDP_DEC_PORT_FILTER_EN
  input  logic [15:0] listen_port,
`endif
  output logic [15:0] src_port,
  output logic [15:0] dest_port,
  output logic [15:0] len_out,
  output logic [31:0] data_out,
  output logic [3:0]  byte_en,
  output logic        wr_en,
  output logic        last,
  output logic        fin,
  output logic        chksum_ok,
  output logic        err
);
  typedef enum logic [2:0] {IDLE, HDR_1, HDR_2, DATA, CHECK, FIN} state_t;
  state_t state_q, state_d;
  logic [15:0] src_port_q, src_port_d, dest_port_q, dest_port_d, len_out_q, len_out_d;
  logic [15:0] bytes_left_q, bytes_left_d;
  logic [31:0] acc_q, acc_d, data_out_q, data_out_d;
  logic [3:0]  byte_en_q, byte_en_d;
  logic wr_en_q, wr_en_d, last_q, last_d, fin_q, fin_d, chksum_ok_q, chksum_ok_d, err_q, err_d;
  logic drop_q, drop_d, rx_zero_q, rx_zero_d;
  logic [15:0] hdr_len, fold;
  logic        len_bad, port_miss;
  logic [3:0]  be;
  logic [31:0] word, acc_in, acc_next;
  logic [32:0] acc_sum;
  logic [34:0] ps;
  logic [17:0] f1;
  logic [16:0] f2;
  assign hdr_len  = data[31:16];
  assign len_bad  = hdr_len < 16'd8 || {1'b0, hdr_len} > {1'b0, MAX_LEN};
  assign be       = bytes_left_q >= 16'd4 ? 4'b1111 : bytes_left_q == 16'd3 ? 4'b1110 :
                    bytes_left_q == 16'd2 ? 4'b1100 : 4'b1000;
  assign word     = data & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign acc_in   = state_q == DATA ? word : data;
  assign acc_sum  = {1'b0, acc_q} + {1'b0, acc_in};
  assign acc_next = acc_sum[31:0] + 32'(acc_sum[32]);
  // pseudo-header is folded in only at CHECK; len_out + 8 recovers the UDP length there
  assign ps   = 35'(acc_q) + 35'(src_ip) + 35'(dest_ip) + 35'({16'h0011, len_out_q + 16'd8});
  assign f1   = 18'(ps[15:0]) + 18'(ps[31:16]) + 18'(ps[34:32]);
  assign f2   = 17'(f1[15:0]) + 17'(f1[17:16]);
  assign fold = f2[15:0] + 16'(f2[16]);
`ifdef UDP_DEC_PORT_FILTER_EN
  assign port_miss = data[15:0] != listen_port;
`else
  assign port_miss = 1'b0;
`endif
  assign src_port  = src_port_q;
  assign dest_port = dest_port_q;
  assign len_out   = len_out_q;
  assign data_out  = data_out_q;
  assign byte_en   = byte_en_q;
  assign wr_en     = wr_en_q;
  assign last      = last_q;
  assign fin       = fin_q;
  assign chksum_ok = chksum_ok_q;
  assign err       = err_q;
  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      src_port_q   <= '0;
      dest_port_q  <= '0;
      len_out_q    <= '0;
      bytes_left_q <= '0;
      acc_q        <= '0;
      data_out_q   <= '0;
      byte_en_q    <= '0;
      wr_en_q      <= 1'b0;
      last_q       <= 1'b0;
      fin_q        <= 1'b0;
      chksum_ok_q  <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
      rx_zero_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_port_q   <= src_port_d;
      dest_port_q  <= dest_port_d;
      len_out_q    <= len_out_d;
      bytes_left_q <= bytes_left_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      byte_en_q    <= byte_en_d;
      wr_en_q      <= wr_en_d;
      last_q       <= last_d;
      fin_q        <= fin_d;
      chksum_ok_q  <= chksum_ok_d;
      err_q        <= err_d;
      drop_q       <= drop_d;
      rx_zero_q    <= rx_zero_d;
    end
  end
  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = HDR_1;
      HDR_1:   if (data_av) state_d = HDR_2;
      HDR_2:   if (data_av) state_d = len_bad ? FIN : hdr_len == 16'd8 ? CHECK : DATA;
      DATA:    if (data_av && bytes_left_q <= 16'd4) state_d = CHECK;
      CHECK:   state_d = FIN;
      FIN:     if (start) state_d = HDR_1;
      default: state_d = IDLE;
    endcase
  end
  // header latching, payload forwarding, checksum accumulation and status
  always_comb begin
    src_port_d   = src_port_q;
    dest_port_d  = dest_port_q;
    len_out_d    = len_out_q;
    bytes_left_d = bytes_left_q;
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    byte_en_d    = byte_en_q;
    wr_en_d      = 1'b0;
    last_d       = 1'b0;
    fin_d        = fin_q;
    chksum_ok_d  = chksum_ok_q;
    err_d        = err_q;
    drop_d       = drop_q;
    rx_zero_d    = rx_zero_q;
    if ((state_q == IDLE || state_q == FIN) && start) begin
      acc_d       = '0;
      drop_d      = 1'b0;
      fin_d       = 1'b0;
      chksum_ok_d = 1'b0;
      err_d       = 1'b0;
    end
    if (state_q == HDR_1 && data_av) begin
      src_port_d  = data[31:16];
      dest_port_d = data[15:0];
      drop_d      = port_miss;
      acc_d       = acc_next;
    end
    if (state_q == HDR_2 && data_av) begin
      len_out_d    = hdr_len - 16'd8;
      bytes_left_d = hdr_len - 16'd8;
      rx_zero_d    = data[15:0] == 16'h0;
      acc_d        = acc_next;
      fin_d        = len_bad;
      err_d        = len_bad;
    end
    if (state_q == DATA && data_av) begin
      data_out_d   = word;
      byte_en_d    = be;
      wr_en_d      = !drop_q;
      last_d       = !drop_q && bytes_left_q <= 16'd4;
      bytes_left_d = bytes_left_q > 16'd4 ? bytes_left_q - 16'd4 : 16'd0;
      acc_d        = acc_next;
    end
    if (state_q == CHECK) begin
      fin_d       = 1'b1;
      err_d       = drop_q;
      chksum_ok_d = !drop_q && (fold == 16'hFFFF || rx_zero_q);
    end
  end
endmodule

// File: tb/tb_udp_decoder.sv
// tb_udp_decoder: randomized and directed datagrams checked against a byte-level checksum/payload model
module tb_udp_decoder;
  localparam int MAX_LEN = 65535;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, data_av = 1'b0;
  logic [31:0] src_ip = '0, dest_ip = '0, data = '0;
  logic [15:0] src_port, dest_port, len_out;
  logic [31:0] data_out;
  logic [3:0]  byte_en;
  logic wr_en, last, fin, chksum_ok, err;
`ifdef UDP_DEC_PORT_FILTER_EN
  logic [15:0] listen_port = 16'h5678;
`endif
  int checks = 0, errors = 0;
  typedef struct packed {logic [31:0] d; logic [3:0] be; logic l;} wr_t;
  wr_t exp_q[$];
  wr_t got_q[$];
  logic [31:0] wq[$];

  always #5 clk = ~clk;

  udp_decoder dut (
    .clk(clk), .reset(reset), .start(start), .src_ip(src_ip), .dest_ip(dest_ip),
    .data(data), .data_av(data_av),
`ifdef UDP_DEC_PORT_FILTER_EN
    .listen_port(listen_port),
`endif
    .src_port(src_port), .dest_port(dest_port), .len_out(len_out), .data_out(data_out),
    .byte_en(byte_en), .wr_en(wr_en), .last(last), .fin(fin), .chksum_ok(chksum_ok), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction

  function automatic logic [3:0] be_of(input int rem);
    return rem >= 4 ? 4'hF : rem == 3 ? 4'hE : rem == 2 ? 4'hC : 4'h8;
  endfunction

  function automatic logic [31:0] mask_of(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  function automatic int words_of(input logic [15:0] len);
    return len < 16'd8 ? 0 : (int'(len) - 8 + 3) / 4;
  endfunction

  // 16-bit one's-complement sum of pseudo-header, header and masked payload
  function automatic logic [15:0] model_sum(input logic [31:0] sip, input logic [31:0] dip);
    logic [15:0] s, len;
    logic [31:0] mw;
    int n;
    len = wq[1][31:16];
    n = words_of(len);
    s = 16'h0011;
    s = add16(add16(s, sip[31:16]), sip[15:0]);
    s = add16(add16(s, dip[31:16]), dip[15:0]);
    s = add16(s, len);
    for (int i = 0; i < 2; i++) s = add16(add16(s, wq[i][31:16]), wq[i][15:0]);
    for (int i = 0; i < n; i++) begin
      mw = wq[2 + i] & mask_of(be_of(int'(len) - 8 - 4 * i));
      s = add16(add16(s, mw[31:16]), mw[15:0]);
    end
    return s;
  endfunction

  always @(negedge clk) begin
    wr_t g, e;
    if (reset && wr_en) begin
      g = '{data_out, byte_en, last};
      got_q.push_back(g);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got %h/%b expected no write", data_out, byte_en);
      end else begin
        e = exp_q.pop_front();
        chk("wr_data", data_out, e.d);
        chk("wr_be", 32'(byte_en), 32'(e.be));
        chk("wr_last", 32'(last), 32'(e.l));
      end
    end
  end

  task automatic send(input logic [31:0] sip, input logic [31:0] dip, input int gap_pct, input int extra);
    logic [15:0] len, pl;
    logic eerr, eok;
    logic [3:0] b;
    wr_t e;
    int n, total, idx, t;
    len = wq[1][31:16];
    pl = len - 16'd8;
    eerr = len < 16'd8 || int'(len) > MAX_LEN;
`ifdef UDP_DEC_PORT_FILTER_EN
    if (wq[0][15:0] != listen_port) eerr = 1'b1;
`endif
    n = words_of(len);
    for (int i = 0; i < n; i++) begin
      b = be_of(int'(pl) - 4 * i);
      e = '{wq[2 + i] & mask_of(b), b, i == n - 1};
      if (!eerr) exp_q.push_back(e);
    end
    eok = !eerr && (model_sum(sip, dip) == 16'hFFFF || wq[1][15:0] == 16'h0);
    @(posedge clk); #1;
    src_ip = sip;
    dest_ip = dip;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fin_clear", 32'(fin), 0);
    total = 2 + n + extra;
    idx = 0;
    while (idx < total) begin
      if (int'($urandom_range(99)) < gap_pct) data_av = 1'b0;
      else begin
        data_av = 1'b1;
        data = idx < wq.size() ? wq[idx] : $urandom();
        idx++;
      end
      @(posedge clk); #1;
    end
    data_av = 1'b0;
    for (t = 0; t < 20; t++) begin
      @(negedge clk);
      if (fin) break;
    end
    chk("fin", 32'(fin), 1);
    chk("err", 32'(err), 32'(eerr));
    chk("chksum_ok", 32'(chksum_ok), 32'(eok));
    chk("src_port", 32'(src_port), 32'(wq[0][31:16]));
    chk("dest_port", 32'(dest_port), 32'(wq[0][15:0]));
    chk("len_out", 32'(len_out), 32'(pl));
    chk("wr_count", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] len, dp, s;
    int n, mode;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fin", 32'(fin), 0);
    chk("rst_ok", 32'(chksum_ok), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_src_port", 32'(src_port), 0);
    chk("rst_dest_port", 32'(dest_port), 0);
    chk("rst_len_out", 32'(len_out), 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_byte_en", 32'(byte_en), 0);
    reset = 1'b1;

    got_q.delete();
    wq = {32'h12345678, 32'h000C7838, 32'hDEADBEEF};
    send(32'hC0A80001, 32'hC0A80002, 0, 0);
    chk("basic_ok", 32'(chksum_ok), 1);
    chk("basic_err", 32'(err), 0);
    chk("basic_data", got_q[0].d, 32'hDEADBEEF);
    chk("basic_be", 32'(got_q[0].be), 32'hF);
    chk("basic_last", 32'(got_q[0].l), 1);
    chk("basic_src", 32'(src_port), 32'h1234);
    chk("basic_len", 32'(len_out), 4);

    got_q.delete();
    wq = {32'h12345678, 32'h000C7839, 32'hDEADBEEF};
    send(32'hC0A80001, 32'hC0A80002, 0, 0);
    chk("badsum_ok", 32'(chksum_ok), 0);
    chk("badsum_err", 32'(err), 0);
    chk("badsum_data", got_q[0].d, 32'hDEADBEEF);

    wq = {32'h12345678, 32'h000C0000, 32'hDEADBEEF};
    send(32'hC0A80001, 32'hC0A80002, 0, 0);
    chk("nosum_ok", 32'(chksum_ok), 1);

    got_q.delete();
    wq = {32'h12345678, 32'h000D0000, 32'hAABBCCDD, 32'hEEFF0011};
    send(32'hC0A80001, 32'hC0A80002, 50, 3);
    chk("odd_count", 32'(got_q.size()), 2);
    chk("odd_d0", got_q[0].d, 32'hAABBCCDD);
    chk("odd_be0", 32'(got_q[0].be), 32'hF);
    chk("odd_d1", got_q[1].d, 32'hEE000000);
    chk("odd_be1", 32'(got_q[1].be), 32'h8);
    chk("odd_last1", 32'(got_q[1].l), 1);
    chk("odd_len", 32'(len_out), 5);

    got_q.delete();
    wq = {32'h12345678, 32'h00060000};
    send(32'hC0A80001, 32'hC0A80002, 0, 2);
    chk("lenerr_err", 32'(err), 1);
    chk("lenerr_ok", 32'(chksum_ok), 0);
    chk("lenerr_wr", 32'(got_q.size()), 0);

    wq = {32'h12345678, 32'h00080000};
    send(32'hC0A80001, 32'hC0A80002, 0, 2);
    chk("len8_err", 32'(err), 0);
    chk("len8_ok", 32'(chksum_ok), 1);
    chk("len8_wr", 32'(got_q.size()), 0);

    // reset between payload words of a two-word datagram
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    data_av = 1'b1;
    data = 32'h12345678;
    @(posedge clk); #1;
    data = 32'h00100000;
    @(posedge clk); #1;
    data = 32'h11111111;
    exp_q.push_back('{32'h11111111, 4'hF, 1'b0});
    @(posedge clk); #1;
    data_av = 1'b0;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_src_port", 32'(src_port), 0);
    chk("midrst_len_out", 32'(len_out), 0);
    chk("midrst_fin", 32'(fin), 0);
    chk("midrst_popped", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    got_q.delete();
    wq = {32'h12345678, 32'h000C7838, 32'hDEADBEEF};
    send(32'hC0A80001, 32'hC0A80002, 0, 0);
    chk("postrst_ok", 32'(chksum_ok), 1);
    chk("postrst_data", got_q[0].d, 32'hDEADBEEF);

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(9) == 0 ? 16'($urandom_range(7)) : 16'(8 + $urandom_range(40));
      dp = $urandom_range(1) == 0 ? 16'h5678 : 16'($urandom());
      n = words_of(len);
      wq = {{16'($urandom()), dp}, {len, 16'h0}};
      for (int i = 0; i < n; i++) wq.push_back($urandom());
      src_ip = $urandom();
      dest_ip = $urandom();
      mode = $urandom_range(2);
      s = model_sum(src_ip, dest_ip);
      if (mode == 0) wq[1][15:0] = ~s;
      else if (mode == 2) wq[1][15:0] = 16'($urandom());
      send(src_ip, dest_ip, int'($urandom_range(40)), int'($urandom_range(3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
